// File: rtl/nn_pkg.sv
// Shared definitions for the NN datapath: sequencer states and ALU op-codes.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_BIAS = 3'd2,
        S_ACT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_SGE  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b111;

endpackage

// File: rtl/neuron_dp.sv
// Combinational neuron datapath: multiply-accumulate, bias add or activation, selected by alu_op.
// NEURON_RELU_EN selects rectified-linear activation instead of the 0/1 step.
module neuron_dp
    import nn_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [2:0]       alu_op,
    input  logic [NBITS-1:0] acc,
    input  logic [NBITS-1:0] x,
    input  logic [NBITS-1:0] w,
    input  logic [NBITS-1:0] bias,
    input  logic [NBITS-1:0] thresh,
    output logic [NBITS-1:0] res
);

    logic [NBITS-1:0] prod;
    logic             ge;

    always_comb begin
        // Low NBITS of the product are identical for signed and unsigned operands.
        prod = x * w;
        ge   = ($signed(acc) >= $signed(thresh));
        res  = acc;
        case (alu_op)
            OP_MUL: res = acc + prod;
            OP_ADD: res = acc + bias;
            OP_SGE: begin
`ifdef NEURON_RELU_EN
                res = ge ? acc : '0;
`else
                res    = '0;
                res[0] = ge;
`endif
            end
            default: res = acc;
        endcase
    end

endmodule

// File: rtl/neuron_seq.sv
// Sequential single-neuron engine: streams NIN (x, w) beats, adds bias, applies threshold activation.
// NEURON_RELU_EN (in neuron_dp) switches the activation to rectified-linear.
module neuron_seq
    import nn_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int NIN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] bias,
    input  logic [NBITS-1:0] thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] x_in,
    input  logic [NBITS-1:0] w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] y_out,
    output logic [NBITS-1:0] acc_out,
    output logic [2:0]       alu_op,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int CW = $clog2(NIN) + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready and out_valid are registered and depend only on state.
    state_t           state;
    logic [NBITS-1:0] acc;
    logic [NBITS-1:0] bias_q;
    logic [NBITS-1:0] thresh_q;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] dp_res;

    assign dbg_state = state;

    neuron_dp #(.NBITS(NBITS)) u_dp (
        .alu_op (alu_op),
        .acc    (acc),
        .x      (x_in),
        .w      (w_in),
        .bias   (bias_q),
        .thresh (thresh_q),
        .res    (dp_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            bias_q    <= '0;
            thresh_q  <= '0;
            y_out     <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            alu_op    <= OP_PASS;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bias_q   <= bias;
                        thresh_q <= thresh;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        alu_op   <= OP_MUL;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (in_valid && in_ready) begin
                        acc <= dp_res;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(NIN - 1)) begin
                            in_ready <= 1'b0;
                            alu_op   <= OP_ADD;
                            state    <= S_BIAS;
                        end
                    end
                end
                S_BIAS: begin
                    acc    <= dp_res;
                    alu_op <= OP_SGE;
                    state  <= S_ACT;
                end
                S_ACT: begin
                    y_out     <= dp_res;
                    acc_out   <= acc;
                    out_valid <= 1'b1;
                    alu_op    <= OP_PASS;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    alu_op    <= OP_PASS;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// Self-checking bench for neuron_seq (NIN=4 main instance, NIN=1 second instance).
module tb_neuron_seq;
    import nn_pkg::*;

    localparam int W   = 32;
    localparam int NIN = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, start1;
    logic [W-1:0] bias, thresh, x_in, w_in;
    logic         in_valid, out_ready, out_ready1;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] y_out, acc_out;
    logic [2:0]   alu_op, dbg_state;
    logic         in_ready1, out_valid1, busy1;
    logic [W-1:0] y_out1, acc_out1;
    logic [2:0]   alu_op1, dbg_state1;

    int n_checks = 0;
    int n_errors = 0;
    int beat_cnt = 0;

    logic [W-1:0] exp_acc_q[$];
    logic [W-1:0] exp_y_q[$];
    logic [W-1:0] xv[NIN];
    logic [W-1:0] wv[NIN];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    neuron_seq #(.NBITS(W), .NIN(NIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .thresh(thresh),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .acc_out(acc_out),
        .alu_op(alu_op), .busy(busy), .dbg_state(dbg_state)
    );

    neuron_seq #(.NBITS(W), .NIN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bias(bias), .thresh(thresh),
        .in_valid(in_valid), .in_ready(in_ready1), .x_in(x_in), .w_in(w_in),
        .out_valid(out_valid1), .out_ready(out_ready1), .y_out(y_out1), .acc_out(acc_out1),
        .alu_op(alu_op1), .busy(busy1), .dbg_state(dbg_state1)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: activation from the pre-activation sum
    function automatic logic [W-1:0] model_act(input logic [W-1:0] a, input logic [W-1:0] t);
        logic ge;
        ge = ($signed(a) >= $signed(t));
`ifdef NEURON_RELU_EN
        return ge ? a : '0;
`else
        return ge ? W'(1) : W'(0);
`endif
    endfunction

    // scoreboard: results and protocol invariants, every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) beat_cnt++;
            if (out_valid) begin
                if (exp_acc_q.size() == 0) begin
                    check("cmp_unexpected_out_valid", W'(out_valid), W'(0));
                end else begin
                    check("cmp_acc_out", acc_out, exp_acc_q[0]);
                    check("cmp_y_out", y_out, exp_y_q[0]);
                    if (out_ready) begin
                        void'(exp_acc_q.pop_front());
                        void'(exp_y_q.pop_front());
                    end
                end
                check("inv_done_op", W'(alu_op), W'(OP_PASS));
                check("inv_done_busy", W'(busy), W'(1));
            end
            if (in_ready) begin
                check("inv_mac_op", W'(alu_op), W'(OP_MUL));
                check("inv_mac_busy", W'(busy), W'(1));
            end
            if (!busy) begin
                check("inv_idle_op", W'(alu_op), W'(OP_PASS));
                check("inv_idle_hs", W'({in_ready, out_valid}), W'(0));
            end
        end
    end

    // driver: one full neuron, called #1 after a rising edge with the DUT in IDLE
    task automatic run_neuron(input string tag, input logic [W-1:0] b, input logic [W-1:0] th,
                              input int gap, input int hold, input bit disturb,
                              input logic [W-1:0] lit_acc, input bit lit_step);
        logic [W-1:0] s, lit_y;
        int idx, gc, waits, n;
        bit ok;
        s = b;
        for (int i = 0; i < NIN; i++) s = s + xv[i] * wv[i];
`ifdef NEURON_RELU_EN
        lit_y = lit_step ? lit_acc : '0;
`else
        lit_y = W'(lit_step);
`endif
        check({tag, "_model_acc"}, s, lit_acc);
        check({tag, "_model_y"}, model_act(s, th), lit_y);
        exp_acc_q.push_back(s);
        exp_y_q.push_back(model_act(s, th));

        beat_cnt = 0;
        start = 1'b1; bias = b; thresh = th;
        @(posedge clk); #1;
        start = disturb; bias = $urandom; thresh = $urandom;
        check({tag, "_in_ready_after_start"}, W'(in_ready), W'(1));

        idx = 0; gc = 0; waits = 0;
        while (idx < NIN && waits < 200) begin
            in_valid = (gc == 0);
            x_in = in_valid ? xv[idx] : $urandom;
            w_in = in_valid ? wv[idx] : $urandom;
            @(negedge clk);
            ok = in_valid && in_ready;
            @(posedge clk); #1;
            if (ok) idx++;
            gc = (gc >= gap) ? 0 : gc + 1;
            waits++;
        end
        check({tag, "_beats_fed"}, W'(idx), W'(NIN));

        if (disturb) begin
            in_valid = 1'b1; x_in = $urandom; w_in = $urandom;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({tag, "_latency"}, W'(n), W'(3));
        in_valid = 1'b0;
        check({tag, "_acc_lit"}, acc_out, lit_acc);
        check({tag, "_y_lit"}, y_out, lit_y);

        repeat (hold) @(negedge clk);
        check({tag, "_acc_held"}, acc_out, lit_acc);
        check({tag, "_ov_held"}, W'(out_valid), W'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        check({tag, "_beats_taken"}, W'(beat_cnt), W'(NIN));
        check({tag, "_ov_after_hs"}, W'(out_valid), W'(0));
        check({tag, "_busy_after_hs"}, W'(busy), W'(0));
    endtask

    initial begin
        int n;
        logic [W-1:0] s1;
        rst_n = 1'b0;
        start = 0; start1 = 0; bias = 0; thresh = 0; x_in = 0; w_in = 0;
        in_valid = 0; out_ready = 0; out_ready1 = 0;
        repeat (3) @(posedge clk); #1;
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_y_out", y_out, W'(0));
        check("rst_acc_out", acc_out, W'(0));
        check("rst_alu_op", W'(alu_op), W'(3'b111));
        check("rst1_alu_op", W'(alu_op1), W'(3'b111));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back pair, then equality and just-above threshold
        xv = '{1, 2, 3, 4}; wv = '{2, 2, 2, 2};
        run_neuron("b2b_a", -5, 0, 0, 0, 0, 15, 1);
        xv = '{1, 2, 3, 4}; wv = '{-1, -1, -1, -1};
        run_neuron("b2b_eq", 0, -10, 0, 0, 0, -10, 1);
        run_neuron("thr_m9", 0, -9, 0, 0, 0, -10, 0);

        // gapped input beats, consumer stalls
        xv = '{3, -4, 5, 6}; wv = '{7, 8, -9, 10};
        run_neuron("gapped", 100, 104, 2, 5, 0, 104, 1);

        // reset in the middle of accumulation
        @(posedge clk); #1;
        start = 1'b1; bias = 32'd77; thresh = 0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; x_in = 9; w_in = 9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_busy", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", W'(in_ready), W'(0));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_y_out", y_out, W'(0));
        check("mid_rst_acc_out", acc_out, W'(0));
        check("mid_rst_alu_op", W'(alu_op), W'(3'b111));
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xv = '{1, 1, 1, 1}; wv = '{1, 1, 1, 1};
        run_neuron("post_rst", 0, 0, 0, 0, 0, 4, 1);

        // stray start / in_valid outside their states
        xv = '{10, 20, 30, 40}; wv = '{-1, 2, -3, 4};
        run_neuron("disturb", -50, 60, 0, 2, 1, 50, 0);

        // NIN=1 instance: single beat with wrapping product
        @(posedge clk); #1;
        start1 = 1'b1; bias = 0; thresh = 0;
        @(posedge clk); #1;
        start1 = 1'b0; in_valid = 1'b1; x_in = 32'h7FFF_FFFF; w_in = 2;
        s1 = x_in * w_in;
        check("n1_model_acc", s1, 32'hFFFF_FFFE);
        @(negedge clk);
        check("n1_in_ready", W'(in_ready1), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid1 && n < 20);
        check("n1_latency", W'(n), W'(3));
        check("n1_acc_out", acc_out1, s1);
        check("n1_y_out", y_out1, model_act(s1, 0));
        check("n1_y_lit", y_out1, W'(0));
        @(posedge clk); #1;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("n1_busy_after_hs", W'(busy1), W'(0));

        repeat (3) @(posedge clk);
        check("queue_drained", W'(exp_acc_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
